// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared opcode constants, FSM state encodings and pipeline-control bundles
// for the hazard stall controller and the EXE-stage forwarding unit.
package hazard_stall_ctrl_pkg;

   localparam logic [6:0] Load   = 7'b0000011;
   localparam logic [6:0] Stype  = 7'b0100011;
   localparam logic [6:0] Itype  = 7'b0010011;
   localparam logic [6:0] Utype  = 7'b0110111;
   localparam logic [6:0] Rtype  = 7'b0110011;
   localparam logic [6:0] Branch = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_FREEZE     = 2'd1;
   localparam logic [1:0] ST_FLUSH_PEND = 2'd2;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_exe_bubble;
      logic pipe_hold;
   } pipe_ctrl_t;

   // Field order: pc_write, if_id_write, if_id_flush, id_exe_bubble, pipe_hold
   localparam pipe_ctrl_t CTRL_RUN      = 5'b11000;
   localparam pipe_ctrl_t CTRL_FLUSH    = 5'b11110;
   localparam pipe_ctrl_t CTRL_LOAD_USE = 5'b00010;
   localparam pipe_ctrl_t CTRL_FREEZE   = 5'b00001;
   localparam pipe_ctrl_t CTRL_RESET    = 5'b00111;

endpackage

// File: rtl/hazard_stall_ctrl_detect.sv
// Combinational load-use decode: which source registers the ID instruction
// reads and whether a load in EXE targets one of them.
module hazard_detect
   import hazard_stall_ctrl_pkg::*;
(
   input  logic [6:0] opcode_ID,
   input  logic [4:0] Read_addr_1_ID,
   input  logic [4:0] Read_addr_2_ID,
   input  logic [6:0] opcode_EXE,
   input  logic [4:0] write_addr_EXE,
   input  logic       RF_write_EXE,
   output logic       uses_rs1,
   output logic       uses_rs2,
   output logic       load_use
);

   always_comb begin
      uses_rs1 = (opcode_ID != Utype) && (opcode_ID != JAL) && (opcode_ID != 7'd0);
      uses_rs2 = (opcode_ID == Rtype) || (opcode_ID == Stype) || (opcode_ID == Branch);
      // x0 is never a real dependency, so a load into x0 cannot stall
      load_use = (opcode_EXE == Load) && RF_write_EXE && (write_addr_EXE != 5'd0) &&
                 ((uses_rs1 && (write_addr_EXE == Read_addr_1_ID)) ||
                  (uses_rs2 && (write_addr_EXE == Read_addr_2_ID)));
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble/flush controller for load-use, cache waits and taken
// branches. Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 255,
   parameter int TO_W         = 8
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode_ID,
   input  logic [4:0]  Read_addr_1_ID,
   input  logic [4:0]  Read_addr_2_ID,
   input  logic [6:0]  opcode_EXE,
   input  logic [4:0]  write_addr_EXE,
   input  logic        RF_write_EXE,
   input  logic        branch_taken_EXE,
   input  logic        Icache_stall,
   input  logic        Dcache_stall,
   output logic        pc_write,
   output logic        IF_ID_write,
   output logic        IF_ID_flush,
   output logic        ID_EXE_bubble,
   output logic        pipe_hold,
   output logic        wait_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_lu_stalls,
   output logic [31:0] perf_freeze_cycles,
   output logic [31:0] perf_flushes
`endif
);

   localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
   localparam logic [TO_W-1:0] CNT_TO  = TO_W'(WAIT_TIMEOUT);

   logic            uses_rs1;
   logic            uses_rs2;
   logic            load_use;
   logic            unused_dec;
   logic            stall_any;
   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [TO_W-1:0] frz_cnt;
   logic            flush_pend;
   logic            timeout_flag;
   pipe_ctrl_t      ctrl;
   pipe_ctrl_t      ctrl_out;

   hazard_detect u_detect (
      .opcode_ID      (opcode_ID),
      .Read_addr_1_ID (Read_addr_1_ID),
      .Read_addr_2_ID (Read_addr_2_ID),
      .opcode_EXE     (opcode_EXE),
      .write_addr_EXE (write_addr_EXE),
      .RF_write_EXE   (RF_write_EXE),
      .uses_rs1       (uses_rs1),
      .uses_rs2       (uses_rs2),
      .load_use       (load_use)
   );

   assign unused_dec = uses_rs1 ^ uses_rs2;
   assign stall_any  = Icache_stall | Dcache_stall;

   // A cache stall dominates every state; a release cycle out of FREEZE decodes as RUN
   always_comb begin
      ctrl      = CTRL_RUN;
      state_nxt = ST_RUN;
      if (stall_any) begin
         ctrl      = CTRL_FREEZE;
         state_nxt = ST_FREEZE;
      end else if (state == ST_FLUSH_PEND) begin
         ctrl = CTRL_FLUSH;
      end else begin
         if (branch_taken_EXE)
            ctrl = CTRL_FLUSH;
         else if (load_use)
            ctrl = CTRL_LOAD_USE;
         if ((state == ST_FREEZE) && flush_pend)
            state_nxt = ST_FLUSH_PEND;
      end
   end

   assign ctrl_out      = rst ? CTRL_RESET : ctrl;
   assign pc_write      = ctrl_out.pc_write;
   assign IF_ID_write   = ctrl_out.if_id_write;
   assign IF_ID_flush   = ctrl_out.if_id_flush;
   assign ID_EXE_bubble = ctrl_out.id_exe_bubble;
   assign pipe_hold     = ctrl_out.pipe_hold;
   assign wait_timeout  = timeout_flag & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_RUN;
         frz_cnt      <= '0;
         flush_pend   <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         if (stall_any) begin
            if (frz_cnt != CNT_MAX)
               frz_cnt <= frz_cnt + TO_W'(1);
            if (frz_cnt == CNT_TO)
               timeout_flag <= 1'b1;
            // The redirect cannot be applied while frozen; remember it for release
            if (branch_taken_EXE)
               flush_pend <= 1'b1;
         end else begin
            frz_cnt <= '0;
            if (state == ST_FLUSH_PEND)
               flush_pend <= 1'b0;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic lu_bubble;
   assign lu_bubble = (ctrl == CTRL_LOAD_USE);

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_lu_stalls     <= '0;
         perf_freeze_cycles <= '0;
         perf_flushes       <= '0;
      end else begin
         if (lu_bubble)
            perf_lu_stalls <= perf_lu_stalls + 32'd1;
         if (state == ST_FREEZE)
            perf_freeze_cycles <= perf_freeze_cycles + 32'd1;
         if (ctrl.if_id_flush)
            perf_flushes <= perf_flushes + 32'd1;
      end
   end
`endif

endmodule
